// File: rtl/display_scan_ctrl_pkg.sv
// display_pkg: shared types and helpers for the display scan controller.
//   state_t            - scan FSM states (IDLE / BLANK / SHOW)
//   NUM_DIGITS         - number of multiplexed digits
//   ANODE_OFF          - active-low anode pattern with every digit off
//   next_enabled_digit - next set bit of a digit mask, searching upward
//                        from index+1 and wrapping 3 -> 0
package display_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      SHOW
   } state_t;

   localparam int unsigned NUM_DIGITS = 4;
   localparam logic [NUM_DIGITS-1:0] ANODE_OFF = '1;

   // Walking the offsets downward lets the smallest matching offset win;
   // offset NUM_DIGITS lands back on index itself, so a lone enabled digit
   // selects itself. Caller guarantees mask is nonzero.
   function automatic logic [1:0] next_enabled_digit(input logic [1:0] index,
                                                     input logic [NUM_DIGITS-1:0] mask);
      logic [1:0] cand;
      logic [1:0] result;
      result = index;
      for (int unsigned i = NUM_DIGITS; i >= 1; i--) begin
         cand = index + 2'(i);
         if (mask[cand]) result = cand;
      end
      return result;
   endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: control/display signal bundle of the scan controller.
//   enable, digit_mask         - scan control (driven by master)
//   brightness                 - dimming level, only with SCAN_DIM_EN defined
//   digit_sel, anode_n, blank,
//   frame_done                 - display drive and status (driven by slave)
// Optional macro: SCAN_DIM_EN.
interface display_scan_ctrl_if;
   import display_pkg::*;

   logic                  enable;
   logic [NUM_DIGITS-1:0] digit_mask;
   logic [1:0]            digit_sel;
   logic [NUM_DIGITS-1:0] anode_n;
   logic                  blank;
   logic                  frame_done;
`ifdef SCAN_DIM_EN
   logic [2:0]            brightness;
`endif

   modport master (
      output enable, digit_mask,
`ifdef SCAN_DIM_EN
      output brightness,
`endif
      input  digit_sel, anode_n, blank, frame_done
   );

   modport slave (
      input  enable, digit_mask,
`ifdef SCAN_DIM_EN
      input  brightness,
`endif
      output digit_sel, anode_n, blank, frame_done
   );

endinterface

// File: rtl/display_scan_ctrl_prescaler.sv
// scan_prescaler: terminal-count counter with synchronous clear.
//   clk, reset - clock, asynchronous active-high reset
//   clear      - forces the count back to zero on the next edge
//   last       - terminal value; tc is high while count == last
//   count      - current count
//   count_nxt  - value count takes on the next edge
//   tc         - terminal count reached (counter wraps to zero)
module scan_prescaler #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic [W-1:0] last,
   output logic [W-1:0] count,
   output logic [W-1:0] count_nxt,
   output logic         tc
);

   always_comb begin
      tc        = (count == last);
      count_nxt = (clear || tc) ? '0 : count + W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) count <= '0;
      else       count <= count_nxt;
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan controller for a 4-digit
// common-anode 7-segment display, with blanking dead time between digits
// and skipping of masked-off digits.
//   clk, reset           - clock, asynchronous active-high reset
//   bus.enable           - scan enable, low forces IDLE
//   bus.digit_mask       - bit i set = digit i takes part in the scan
//   bus.digit_sel        - digit index to the 7-segment decoder
//   bus.anode_n          - active-low anode enables, at most one low
//   bus.blank            - high whenever all anodes are off
//   bus.frame_done       - one-cycle pulse on each scan wrap
//   bus.brightness       - dimming level (SCAN_DIM_EN only)
// Optional macro: SCAN_DIM_EN adds brightness-controlled dimming in SHOW.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int unsigned DIV       = 50000,
   parameter int unsigned BLANK_CYC = 16,
   parameter int unsigned DIV_W     = $clog2(DIV)
) (
   input  logic                clk,
   input  logic                reset,
   display_scan_ctrl_if.slave  bus
);

   // One counter times both phases, so it must fit the longer of the two.
   localparam int unsigned BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   localparam int unsigned CNT_W = (DIV_W > BLK_W) ? DIV_W : BLK_W;
   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

   state_t                state, state_n;
   logic [1:0]            sel_q, sel_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;
   logic                  blank_q, blank_d;
   logic                  frame_q, frame_d;
   logic [1:0]            nxt_digit;
   logic [31:0]           show_len;

   logic                  cnt_clr;
   logic                  cnt_tc;
   logic [CNT_W-1:0]      cnt, cnt_nxt, cnt_last;

`ifdef SCAN_DIM_EN
   logic [2:0]            bright_q, bright_d;
`endif

   scan_prescaler #(.W(CNT_W)) u_prescaler (
      .clk       (clk),
      .reset     (reset),
      .clear     (cnt_clr),
      .last      (cnt_last),
      .count     (cnt),
      .count_nxt (cnt_nxt),
      .tc        (cnt_tc)
   );

   always_comb begin
      state_n   = state;
      sel_d     = sel_q;
      frame_d   = 1'b0;
      cnt_clr   = 1'b0;
      cnt_last  = (state == SHOW) ? DIV_LAST : BLANK_LAST;
      nxt_digit = next_enabled_digit(sel_q, bus.digit_mask);
`ifdef SCAN_DIM_EN
      bright_d  = bright_q;
`endif

      if (!bus.enable) begin
         state_n = IDLE;
         sel_d   = '0;
         cnt_clr = 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               cnt_clr = 1'b1;
               if (bus.digit_mask != '0) begin
                  state_n = BLANK;
                  // Searching upward from digit 3 wraps to the lowest set bit.
                  sel_d   = next_enabled_digit(2'd3, bus.digit_mask);
               end
            end
            BLANK: begin
               if (cnt_tc) begin
                  state_n  = SHOW;
                  cnt_clr  = 1'b1;
`ifdef SCAN_DIM_EN
                  bright_d = bus.brightness;
`endif
               end
            end
            SHOW: begin
               if (cnt_tc) begin
                  cnt_clr = 1'b1;
                  if (bus.digit_mask == '0) begin
                     state_n = IDLE;
                     sel_d   = '0;
                  end else begin
                     state_n = BLANK;
                     sel_d   = nxt_digit;
                     frame_d = (nxt_digit <= sel_q);
                  end
               end
            end
            default: begin
               state_n = IDLE;
               sel_d   = '0;
               cnt_clr = 1'b1;
            end
         endcase
      end

      // Anode drive is computed from next-cycle state and count so the
      // outputs can be registered without adding a cycle of lag.
`ifdef SCAN_DIM_EN
      show_len = ((32'(bright_d) + 32'd1) * DIV) >> 3;
`else
      show_len = DIV;
`endif
      anode_d = ANODE_OFF;
      if (state_n == SHOW && 32'(cnt_nxt) < show_len)
         anode_d = ~(NUM_DIGITS'(1) << sel_d);
      blank_d = (anode_d == ANODE_OFF);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         sel_q   <= '0;
         anode_q <= ANODE_OFF;
         blank_q <= 1'b1;
         frame_q <= 1'b0;
`ifdef SCAN_DIM_EN
         bright_q <= '0;
`endif
      end else begin
         state   <= state_n;
         sel_q   <= sel_d;
         anode_q <= anode_d;
         blank_q <= blank_d;
         frame_q <= frame_d;
`ifdef SCAN_DIM_EN
         bright_q <= bright_d;
`endif
      end
   end

   assign bus.digit_sel  = sel_q;
   assign bus.anode_n    = anode_q;
   assign bus.blank      = blank_q;
   assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench for display_scan_ctrl.
// Stimulus is applied on falling edges; a reference model built around the
// per-digit period (position within period, current digit) predicts the
// outputs after the following rising edge and queues them. A monitor pops
// and compares after every rising edge.
module tb_display_scan_ctrl;
   import display_pkg::*;

`ifdef SCAN_DIM_EN
   localparam int unsigned DIV = 8;
`else
   localparam int unsigned DIV = 4;
`endif
   localparam int unsigned BLANK_CYC = 2;
   localparam int unsigned PERIOD    = BLANK_CYC + DIV;

   typedef struct {
      logic [1:0] sel;
      logic [3:0] anode;
      logic       blank;
      logic       frame;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   display_scan_ctrl_if dif();

   display_scan_ctrl #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model state
   bit m_active = 0;
   int m_pos    = 0;
   int m_cur    = 0;
   int m_br     = 7;
   bit m_frame  = 0;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
      end
   endtask

   function automatic int lowest_set(input logic [3:0] m);
      int r = 0;
      for (int i = 3; i >= 0; i--) if (m[i]) r = i;
      return r;
   endfunction

   function automatic int next_set(input int cur, input logic [3:0] m);
      int r = cur;
      for (int k = 4; k >= 1; k--) if (m[(cur + k) % 4]) r = (cur + k) % 4;
      return r;
   endfunction

   task automatic model_step(input bit r, input bit en, input logic [3:0] m, input int br);
      int nd;
      m_frame = 0;
      if (r || !en) begin
         m_active = 0; m_pos = 0; m_cur = 0;
      end else if (!m_active) begin
         if (m != 0) begin
            m_active = 1; m_pos = 0; m_cur = lowest_set(m);
         end
      end else if (m_pos == PERIOD - 1) begin
         if (m == 0) begin
            m_active = 0; m_pos = 0; m_cur = 0;
         end else begin
            nd = next_set(m_cur, m);
            m_frame = (nd <= m_cur);
            m_cur = nd;
            m_pos = 0;
         end
      end else begin
         m_pos++;
      end
      if (m_active && m_pos == BLANK_CYC) m_br = br;
   endtask

   function automatic exp_t model_out();
      exp_t e;
      logic [3:0] one = 4'b0001;
      int lit_len = ((m_br + 1) * DIV) >> 3;
      bit lit = m_active && m_pos >= BLANK_CYC && (m_pos - BLANK_CYC) < lit_len;
      e.sel   = m_active ? 2'(m_cur) : 2'd0;
      e.anode = lit ? ~(one << m_cur) : 4'hF;
      e.blank = !lit;
      e.frame = m_frame;
      return e;
   endfunction

   task automatic cycle(input bit r, input bit en, input logic [3:0] m);
      int br;
      @(negedge clk);
`ifdef SCAN_DIM_EN
      br = $urandom_range(0, 7);
      dif.brightness = 3'(br);
`else
      br = 7;
`endif
      reset = r;
      dif.enable = en;
      dif.digit_mask = m;
      model_step(r, en, m, br);
      exp_q.push_back(model_out());
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_digit_sel"}, int'(dif.digit_sel), 0);
      chk({tag, "_anode_n"}, int'(dif.anode_n), 15);
      chk({tag, "_blank"}, int'(dif.blank), 1);
      chk({tag, "_frame_done"}, int'(dif.frame_done), 0);
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("digit_sel", int'(dif.digit_sel), int'(e.sel));
            chk("anode_n", int'(dif.anode_n), int'(e.anode));
            chk("blank", int'(dif.blank), int'(e.blank));
            chk("frame_done", int'(dif.frame_done), int'(e.frame));
         end
      end
   end

   // Stimulus
   initial begin
      int guard;
      logic [3:0] mask;
      bit en;
      reset = 1'b1;
      dif.enable = 1'b0;
      dif.digit_mask = '0;
`ifdef SCAN_DIM_EN
      dif.brightness = 3'd7;
`endif
      #2;
      check_reset_values("por");
      cycle(1, 0, 4'h0);
      cycle(1, 1, 4'hF);

      // Full mask, then alternating digits, then a lone digit
      repeat (30) cycle(0, 1, 4'hF);
      repeat (30) cycle(0, 1, 4'h5);
      repeat (20) cycle(0, 1, 4'h8);

      // Mask cleared mid-dwell, then restored to digit 1 only
      guard = 0;
      do begin cycle(0, 1, 4'hF); guard++; end
      while (!(m_active && m_pos == BLANK_CYC + 1) && guard < 40);
      chk("reach_mid_show_mask", guard < 40, 1);
      repeat (12) cycle(0, 1, 4'h0);
      repeat (15) cycle(0, 1, 4'h2);

      // Enable dropped mid-dwell
      guard = 0;
      do begin cycle(0, 1, 4'hF); guard++; end
      while (!(m_active && m_pos == BLANK_CYC + 1) && guard < 40);
      chk("reach_mid_show_en", guard < 40, 1);
      cycle(0, 0, 4'hF);
      repeat (3) cycle(0, 0, 4'hF);
      repeat (10) cycle(0, 1, 4'hF);

      // Asynchronous reset while the DUT sits in BLANK
      guard = 0;
      do begin cycle(0, 1, 4'hF); guard++; end
      while (!(m_active && m_pos == 0) && guard < 40);
      chk("reach_blank", guard < 40, 1);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_reset_values("async_rst");
      cycle(1, 1, 4'hF);
      cycle(1, 1, 4'hF);
      repeat (10) cycle(0, 1, 4'hF);

      // Random mask/enable traffic
      mask = 4'hF;
      en = 1;
      repeat (400) begin
         if ($urandom_range(0, 11) == 0) mask = 4'($urandom);
         en = ($urandom_range(0, 40) != 0);
         cycle(0, en, mask);
      end

      @(posedge clk);
      #3;
      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
